// File: rtl/senzor_apb_hub.sv
// -----------------------------------------------------------------------------
// senzor_apb_hub
// APB register and sample-buffer hub for the colour-sensor subsystem.
//   - CONFIG / SEED / THRESH control registers. CONFIG and SEED are frozen
//     while the I2C engine reports busy.
//   - Per-channel "last sample" registers and a sample FIFO with overflow flag.
//   - Threshold interrupt on the FIFO level.
// APB slave with one wait state. The first access cycle decodes the access
// and registers prdata/pslverr. The second cycle raises pready and commits
// the write or FIFO pop.
//
// Ports
//   clk, rst_n                    system clock, async active-low reset
//   psel/penable/pwrite/paddr/pwdata   APB request
//   pready/prdata/pslverr         APB response (prdata, pslverr registered)
//   smp_valid/smp_ch/smp_data     sample strobe from I2C control
//   busy, nack                    I2C status inputs
//   cfg_*                         CONFIG fields
//   seed_wr, seed_data            SEED commit pulse and value
//   irq                           FIFO threshold interrupt (level)
// -----------------------------------------------------------------------------
module senzor_apb_hub #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 5,
    parameter int CH_WIDTH   = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic                  pready,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pslverr,
    input  logic                  smp_valid,
    input  logic [2:0]            smp_ch,
    input  logic [CH_WIDTH-1:0]   smp_data,
    input  logic                  busy,
    input  logic                  nack,
    output logic                  cfg_sd,
    output logic                  cfg_endian,
    output logic [1:0]            cfg_speed,
    output logic [6:0]            cfg_i2c_addr,
    output logic [NUM_CH-1:0]     cfg_ch_en,
    output logic                  seed_wr,
    output logic [15:0]           seed_data,
    output logic                  irq
);

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LVL_W  = PTR_W + 1;
    localparam int WORD_W = CH_WIDTH + 3;
    localparam int NBYTES = CH_WIDTH / 8;

    localparam logic [ADDR_WIDTH-1:0] A_CONFIG = ADDR_WIDTH'('h00);
    localparam logic [ADDR_WIDTH-1:0] A_SEED   = ADDR_WIDTH'('h04);
    localparam logic [ADDR_WIDTH-1:0] A_STATUS = ADDR_WIDTH'('h08);
    localparam logic [ADDR_WIDTH-1:0] A_FIFO   = ADDR_WIDTH'('h0C);
    localparam logic [ADDR_WIDTH-1:0] A_THRESH = ADDR_WIDTH'('h10);

    // APB handshake state
    logic                  r_phase;      // 1 during the second access cycle
    logic                  r_pslverr;
    logic [DATA_WIDTH-1:0] r_prdata;

    // Control registers
    logic                  r_sd, r_endian, r_irq_en;
    logic [1:0]            r_speed;
    logic [6:0]            r_i2c_addr;
    logic [NUM_CH-1:0]     r_ch_en;
    logic [15:0]           r_seed;
    logic                  r_seed_wr;
    logic [5:0]            r_thresh;
    logic                  r_ovf, r_irq;

    // Sample storage
    logic [CH_WIDTH-1:0]   r_ch  [NUM_CH];
    logic [WORD_W-1:0]     r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr, r_rd_ptr;
    logic [LVL_W-1:0]      r_level;

    logic                  w_access, w_commit, w_wr;
    logic                  w_empty, w_full;
    logic                  w_hit_cfg, w_hit_seed, w_hit_stat, w_hit_fifo, w_hit_thr, w_hit_ch;
    logic                  w_err;
    logic [CH_WIDTH-1:0]   w_ch_rdata;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic                  w_cfg_wr, w_seed_wr, w_stat_wr, w_thr_wr, w_pop;
    logic [7:0]            w_ch_en8;
    logic                  w_accept, w_push, w_ovf_set;
    logic [CH_WIDTH-1:0]   w_sample;
    logic [LVL_W-1:0]      w_level_nxt;
    logic [5:0]            w_thresh_nxt;
    logic                  w_irq_en_nxt, w_irq_nxt;
    logic                  w_unused;

    assign w_access = psel & penable;
    // The error captured in the first cycle gates the commit in the second.
    assign w_commit = w_access & r_phase & ~r_pslverr;
    assign w_wr     = w_commit & pwrite;
    assign w_empty  = (r_level == '0);
    assign w_full   = (r_level == LVL_W'(FIFO_DEPTH));

    // Address decode, error classification and read mux.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_hit_cfg  = (paddr == A_CONFIG);
        w_hit_seed = (paddr == A_SEED);
        w_hit_stat = (paddr == A_STATUS);
        w_hit_fifo = (paddr == A_FIFO);
        w_hit_thr  = (paddr == A_THRESH);
        w_hit_ch   = 1'b0;
        w_ch_rdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (paddr == ADDR_WIDTH'(32 + 4 * i)) begin
                w_hit_ch = 1'b1;
                if (r_ch_en[i]) w_ch_rdata = r_ch[i];
            end
        end

        w_err = (paddr[1:0] != 2'b00)
              | ~(w_hit_cfg | w_hit_seed | w_hit_stat | w_hit_fifo | w_hit_thr | w_hit_ch)
              | (pwrite & (w_hit_fifo | w_hit_ch))
              | (pwrite & busy & (w_hit_cfg | w_hit_seed))
              | (~pwrite & w_hit_fifo & w_empty);

        w_rdata = '0;
        if (w_hit_cfg) begin
            w_rdata[0]             = r_sd;
            w_rdata[1]             = r_endian;
            w_rdata[2]             = r_irq_en;
            w_rdata[4:3]           = r_speed;
            w_rdata[11:5]          = r_i2c_addr;
            w_rdata[16 +: NUM_CH]  = r_ch_en;
        end
        if (w_hit_seed) w_rdata[15:0] = r_seed;
        if (w_hit_stat) begin
            // A full 64-deep FIFO wraps the 6-bit level field; the full flag disambiguates.
            w_rdata[5:0] = 6'(r_level);
            w_rdata[8]   = w_empty;
            w_rdata[9]   = w_full;
            w_rdata[10]  = r_ovf;
            w_rdata[11]  = busy;
            w_rdata[12]  = nack;
        end
        if (w_hit_fifo && !w_empty) w_rdata[WORD_W-1:0] = r_mem[r_rd_ptr];
        if (w_hit_thr)  w_rdata[5:0] = r_thresh;
        if (w_hit_ch)   w_rdata[CH_WIDTH-1:0] = w_ch_rdata;
        if (w_err)      w_rdata = '0;
    end

    assign w_cfg_wr  = w_wr & w_hit_cfg;
    assign w_seed_wr = w_wr & w_hit_seed;
    assign w_stat_wr = w_wr & w_hit_stat;
    assign w_thr_wr  = w_wr & w_hit_thr;
    // The head word was already captured into prdata, so the pop only advances the pointer.
    assign w_pop     = w_commit & ~pwrite & w_hit_fifo;

    // Sample acceptance. The enable vector is widened to 8 bits so any 3-bit index is in range.
    assign w_ch_en8  = 8'(r_ch_en);
    assign w_accept  = smp_valid & ~r_sd & ({1'b0, smp_ch} < 4'(NUM_CH)) & w_ch_en8[smp_ch];
    assign w_push    = w_accept & (~w_full | w_pop);
    assign w_ovf_set = w_accept & w_full & ~w_pop;

    always_comb begin
        w_sample = smp_data;
        if (r_endian) begin
            for (int b = 0; b < NBYTES; b++)
                w_sample[8*b +: 8] = smp_data[CH_WIDTH-8-8*b +: 8];
        end
    end

    // irq is registered from next-state values so it tracks the level with no extra lag.
    assign w_level_nxt  = r_level + LVL_W'(w_push) - LVL_W'(w_pop);
    assign w_thresh_nxt = w_thr_wr ? pwdata[5:0] : r_thresh;
    assign w_irq_en_nxt = w_cfg_wr ? pwdata[2] : r_irq_en;
    assign w_irq_nxt    = w_irq_en_nxt & (7'(w_level_nxt) >= 7'(w_thresh_nxt))
                        & (w_thresh_nxt != 6'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase    <= 1'b0;
            r_pslverr  <= 1'b0;
            r_prdata   <= '0;
            r_sd       <= 1'b1;
            r_endian   <= 1'b0;
            r_irq_en   <= 1'b0;
            r_speed    <= '0;
            r_i2c_addr <= '0;
            r_ch_en    <= '0;
            r_seed     <= '0;
            r_seed_wr  <= 1'b0;
            r_thresh   <= 6'd1;
            r_ovf      <= 1'b0;
            r_irq      <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            for (int i = 0; i < NUM_CH; i++) r_ch[i] <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
            if (w_access && !r_phase) begin
                r_phase   <= 1'b1;
                r_pslverr <= w_err;
                if (!pwrite) r_prdata <= w_rdata;
            end else begin
                r_phase   <= 1'b0;
            end

            if (w_cfg_wr) begin
                r_sd       <= pwdata[0];
                r_endian   <= pwdata[1];
                r_irq_en   <= pwdata[2];
                r_speed    <= pwdata[4:3];
                r_i2c_addr <= pwdata[11:5];
                r_ch_en    <= pwdata[16 +: NUM_CH];
            end
            if (w_seed_wr) r_seed   <= pwdata[15:0];
            r_seed_wr <= w_seed_wr;
            r_thresh  <= w_thresh_nxt;

            // A new overflow in the same cycle as a W1C wins, so no event is lost.
            if (w_ovf_set)                    r_ovf <= 1'b1;
            else if (w_stat_wr && pwdata[10]) r_ovf <= 1'b0;

            for (int i = 0; i < NUM_CH; i++)
                if (w_accept && smp_ch == 3'(i)) r_ch[i] <= w_sample;

            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_level <= w_level_nxt;
            r_irq   <= w_irq_nxt;
        end
    end

    // NOTE: FIFO storage has no reset; the level counter alone defines which words are valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {smp_ch, w_sample};
    end

    assign pready       = w_access & r_phase;
    assign prdata       = r_prdata;
    assign pslverr      = r_pslverr;
    assign cfg_sd       = r_sd;
    assign cfg_endian   = r_endian;
    assign cfg_speed    = r_speed;
    assign cfg_i2c_addr = r_i2c_addr;
    assign cfg_ch_en    = r_ch_en;
    assign seed_wr      = r_seed_wr;
    assign seed_data    = r_seed;
    assign irq          = r_irq;

    // Write-data bits with no register behind them.
    assign w_unused = ^pwdata;

endmodule
